clock_display_rx: RTL and testbench
===================================

Name: clock_display_rx

Overview:
Receiver for the clock's serial display stream (serial clock, latch, data bit). Oversamples the three serial lines in the system clock domain, deserialises a 48-bit frame of six 7-segment patterns, and decodes each pattern back to BCD. On each latch it presents seconds, minutes and hours as packed BCD. Used as a display-side model and as a loopback checker next to the clock core.

Parameters:
N_DIGITS, 6, digits per frame
BITS_PER_DIGIT, 8, bits per digit pattern
SYNC_STAGES, 2, synchroniser flops on each serial input (minimum 2)

Ports:
i_clk  in  1  system clock; all logic on rising edge
i_rst  in  1  asynchronous reset, active-high
i_sr_clk  in  1  serial shift clock from the transmitter
i_sr_latch  in  1  frame latch strobe from the transmitter
i_sr_bit  in  1  serial data bit
o_seconds  out  8  BCD seconds {tens,units}
o_minutes  out  8  BCD minutes {tens,units}
o_hours  out  8  BCD hours {tens,units}
o_valid  out  1  one-cycle pulse when a good frame is committed
o_frame_err  out  1  sticky error flag for the last latched frame

Behaviour:
- Reset (async, active-high): o_seconds, o_minutes and o_hours = 8'h00; o_valid = 0; o_frame_err = 0; shift register, bit counter and synchronisers cleared.
- Synchronisers: each input passes through SYNC_STAGES flops. A one-flop history of the synchronised clock and latch provides rising-edge detect.
- Shift: on a detected i_sr_clk rising edge, shift the synchronised bit into a 48-bit register, LSB end in, MSB first within each byte.
- Bit counter: 0..49, saturating at 49. A value of 49 means overflow.
- Frame format: 6 bytes, 48 bits total. Digit 0 (seconds units) is sent first and digit 5 (hours tens) last.
- Segment byte: {dp,g,f,e,d,c,b,a}, active-high, dp must be 0.
- Valid patterns: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Any other byte is a decode error.
- Latch: on a detected i_sr_latch rising edge, evaluate the frame:
  - Good frame: count == 48, all six bytes decode, and the range check passes.
  - Range check: seconds tens ≤ 5, minutes tens ≤ 5, hours ≤ BCD 23.
  - Good frame response: register all three BCD outputs, pulse o_valid high for exactly 1 cycle, clear o_frame_err.
  - Bad frame response (short, long, bad pattern or out of range): outputs hold their previous values, o_valid stays 0, o_frame_err = 1.
  - In both cases the bit counter is cleared.
- Latency: outputs and o_valid change on the 3rd i_clk edge, counting the edge at which the first sync stage captures latch high (for SYNC_STAGES = 2).
- Simultaneous events: a serial-clock edge and a latch edge detected in the same cycle: the shift is applied first, and the latch evaluates the updated register and count.
- Latch with no bits (count 0) is an error.
- Serial-clock edges while latch is high still shift and count toward the next frame.
- Transmitter contract: i_sr_bit is stable for ≥ SYNC_STAGES+1 i_clk cycles around each i_sr_clk rising edge, and each serial-clock high/low phase lasts ≥ SYNC_STAGES+1 i_clk cycles. Faster streams are out of spec and not checked.
- Reset mid-frame discards the partial frame. The first latch after reset with fewer than 48 bits flags an error.

Decomposition:
- Shared package:
  - segment pattern constants SEG_0..SEG_9;
  - FRAME_BITS = N_DIGITS*BITS_PER_DIGIT;
  - digit index constants DIG_S_U..DIG_H_T;
  - BCD range limits 8'h59 and 8'h23.
- One sub-module: seg7_to_bcd. Purely combinational 8-bit pattern to {4-bit digit, invalid flag}; six instances. The inverse of the team's BCD-to-segment decoder.
- Synchroniser and edge-detect stay inline.

Test Plan:
- Reset, then idle lines -> all BCD outputs 8'h00, o_valid 0, o_frame_err 0.
- Frame for 12:34:56 (bytes 7D,6D,66,4F,5B,06), then latch -> o_hours 8'h12, o_minutes 8'h34, o_seconds 8'h56, o_valid a single 1-cycle pulse, o_frame_err 0.
- 47-bit frame, then latch -> outputs hold 12:34:56, o_frame_err 1. A following good frame 23:59:59 clears the error and updates the outputs.
- Frame with seconds-units byte 00 (blank), or minutes tens = 6 (7D) -> o_frame_err 1, no o_valid pulse, outputs unchanged.
- Assert i_rst after 20 bits, release, send a full frame for 00:00:01 -> outputs 00:00:01, o_valid pulse, no error.
- Last serial-clock edge and latch edge in the same i_clk cycle, 48 bits total -> accepted as a good frame. Then send 49 bits and latch -> o_frame_err 1.

Source files
------------

// File: rtl/clock_display_rx_pkg.sv
// ============================================================================
// clock_display_rx_pkg : shared constants for the serial display receiver
// Rev 1.0
// ============================================================================
`default_nettype none

package clock_display_rx_pkg;

  localparam int DEF_N_DIGITS       = 6;
  localparam int DEF_BITS_PER_DIGIT = 8;
  localparam int FRAME_BITS         = DEF_N_DIGITS * DEF_BITS_PER_DIGIT;

  // Segment byte layout {dp,g,f,e,d,c,b,a}, active-high
  localparam logic [7:0] SEG_0 = 8'h3F;
  localparam logic [7:0] SEG_1 = 8'h06;
  localparam logic [7:0] SEG_2 = 8'h5B;
  localparam logic [7:0] SEG_3 = 8'h4F;
  localparam logic [7:0] SEG_4 = 8'h66;
  localparam logic [7:0] SEG_5 = 8'h6D;
  localparam logic [7:0] SEG_6 = 8'h7D;
  localparam logic [7:0] SEG_7 = 8'h07;
  localparam logic [7:0] SEG_8 = 8'h7F;
  localparam logic [7:0] SEG_9 = 8'h6F;

  // Digit indices in transmission order
  localparam int DIG_S_U = 0;
  localparam int DIG_S_T = 1;
  localparam int DIG_M_U = 2;
  localparam int DIG_M_T = 3;
  localparam int DIG_H_U = 4;
  localparam int DIG_H_T = 5;

  localparam logic [7:0] BCD_MS_MAX = 8'h59;
  localparam logic [7:0] BCD_HR_MAX = 8'h23;

endpackage

`default_nettype wire

// File: rtl/clock_display_rx_seg7_to_bcd.sv
// ============================================================================
// seg7_to_bcd : combinational 7-segment pattern to BCD digit with invalid flag
// Rev 1.0
// ============================================================================
`default_nettype none

module seg7_to_bcd
  import clock_display_rx_pkg::*;
(
  input  logic [7:0] i_seg,
  output logic [3:0] o_digit,
  output logic       o_invalid
);

  always_comb begin
    o_digit   = 4'd0;
    o_invalid = 1'b0;
    case (i_seg)
      SEG_0:   o_digit = 4'd0;
      SEG_1:   o_digit = 4'd1;
      SEG_2:   o_digit = 4'd2;
      SEG_3:   o_digit = 4'd3;
      SEG_4:   o_digit = 4'd4;
      SEG_5:   o_digit = 4'd5;
      SEG_6:   o_digit = 4'd6;
      SEG_7:   o_digit = 4'd7;
      SEG_8:   o_digit = 4'd8;
      SEG_9:   o_digit = 4'd9;
      default: o_invalid = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/clock_display_rx.sv
// ============================================================================
// clock_display_rx : oversampling receiver for the serial 7-segment stream
// Rev 1.0
// ============================================================================
`default_nettype none

module clock_display_rx
  import clock_display_rx_pkg::*;
#(
  parameter int N_DIGITS       = DEF_N_DIGITS,
  parameter int BITS_PER_DIGIT = DEF_BITS_PER_DIGIT,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sr_clk,
  input  logic       i_sr_latch,
  input  logic       i_sr_bit,
  output logic [7:0] o_seconds,
  output logic [7:0] o_minutes,
  output logic [7:0] o_hours,
  output logic       o_valid,
  output logic       o_frame_err
);

  localparam int C_FRAME_BITS = N_DIGITS * BITS_PER_DIGIT;
  localparam int C_CNT_W      = $clog2(C_FRAME_BITS + 2);
  localparam logic [C_CNT_W-1:0] C_CNT_FULL = C_CNT_W'(C_FRAME_BITS);
  localparam logic [C_CNT_W-1:0] C_CNT_OVF  = C_CNT_W'(C_FRAME_BITS + 1);

  logic [SYNC_STAGES-1:0]  r_sclk_sync;
  logic [SYNC_STAGES-1:0]  r_latch_sync;
  logic [SYNC_STAGES-1:0]  r_bit_sync;
  logic                    r_sclk_d;
  logic                    r_latch_d;
  logic [C_FRAME_BITS-1:0] r_sreg;
  logic [C_CNT_W-1:0]      r_cnt;
  logic [7:0]              r_seconds;
  logic [7:0]              r_minutes;
  logic [7:0]              r_hours;
  logic                    r_valid;
  logic                    r_frame_err;

  logic                    w_sclk;
  logic                    w_latch;
  logic                    w_bit;
  logic                    w_sclk_rise;
  logic                    w_latch_rise;
  logic [C_FRAME_BITS-1:0] w_sreg_next;
  logic [C_CNT_W-1:0]      w_cnt_next;
  logic [3:0]              w_dig [N_DIGITS];
  logic [N_DIGITS-1:0]     w_inv;
  logic [7:0]              w_sec;
  logic [7:0]              w_min;
  logic [7:0]              w_hr;
  logic                    w_good;

  assign w_sclk       = r_sclk_sync[SYNC_STAGES-1];
  assign w_latch      = r_latch_sync[SYNC_STAGES-1];
  assign w_bit        = r_bit_sync[SYNC_STAGES-1];
  assign w_sclk_rise  = w_sclk & ~r_sclk_d;
  assign w_latch_rise = w_latch & ~r_latch_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sclk_sync  <= '0;
      r_latch_sync <= '0;
      r_bit_sync   <= '0;
      r_sclk_d     <= 1'b0;
      r_latch_d    <= 1'b0;
    end else begin
      r_sclk_sync  <= {r_sclk_sync[SYNC_STAGES-2:0], i_sr_clk};
      r_latch_sync <= {r_latch_sync[SYNC_STAGES-2:0], i_sr_latch};
      r_bit_sync   <= {r_bit_sync[SYNC_STAGES-2:0], i_sr_bit};
      r_sclk_d     <= w_sclk;
      r_latch_d    <= w_latch;
    end
  end

  // The latch judges the post-shift view so a coincident final clock edge counts.
  always_comb begin
    w_sreg_next = r_sreg;
    w_cnt_next  = r_cnt;
    if (w_sclk_rise) begin
      w_sreg_next = {r_sreg[C_FRAME_BITS-2:0], w_bit};
      if (r_cnt != C_CNT_OVF) begin
        w_cnt_next = r_cnt + 1'b1;
      end
    end
  end

  // First-sent digit ends up in the most significant byte.
  for (genvar k = 0; k < N_DIGITS; k++) begin : g_dec
    seg7_to_bcd u_dec (
      .i_seg     (w_sreg_next[C_FRAME_BITS-1-k*BITS_PER_DIGIT -: BITS_PER_DIGIT]),
      .o_digit   (w_dig[k]),
      .o_invalid (w_inv[k])
    );
  end

  assign w_sec  = {w_dig[DIG_S_T], w_dig[DIG_S_U]};
  assign w_min  = {w_dig[DIG_M_T], w_dig[DIG_M_U]};
  assign w_hr   = {w_dig[DIG_H_T], w_dig[DIG_H_U]};
  assign w_good = (w_cnt_next == C_CNT_FULL) && (w_inv == '0) &&
                  (w_sec <= BCD_MS_MAX) && (w_min <= BCD_MS_MAX) &&
                  (w_hr <= BCD_HR_MAX);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sreg      <= '0;
      r_cnt       <= '0;
      r_seconds   <= 8'h00;
      r_minutes   <= 8'h00;
      r_hours     <= 8'h00;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_sreg  <= w_sreg_next;
      r_valid <= 1'b0;
      if (w_latch_rise) begin
        r_cnt <= '0;
        if (w_good) begin
          r_seconds   <= w_sec;
          r_minutes   <= w_min;
          r_hours     <= w_hr;
          r_valid     <= 1'b1;
          r_frame_err <= 1'b0;
        end else begin
          r_frame_err <= 1'b1;
        end
      end else begin
        r_cnt <= w_cnt_next;
      end
    end
  end

  assign o_seconds   = r_seconds;
  assign o_minutes   = r_minutes;
  assign o_hours     = r_hours;
  assign o_valid     = r_valid;
  assign o_frame_err = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_clock_display_rx.sv
// ============================================================================
// tb_clock_display_rx : randomized self-checking bench with a behavioural model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_clock_display_rx;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_sr_clk = 1'b0;
  logic       i_sr_latch = 1'b0;
  logic       i_sr_bit = 1'b0;
  logic [7:0] o_seconds;
  logic [7:0] o_minutes;
  logic [7:0] o_hours;
  logic       o_valid;
  logic       o_frame_err;

  int vectors = 0;
  int miscompares = 0;
  int vcount = 0;

  // Behavioural model state
  bit         bitq[$];
  int         exp_s = 0, exp_m = 0, exp_h = 0;
  bit         exp_err = 1'b0;
  int         exp_pulses = 0;
  logic [7:0] segs [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                            8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  clock_display_rx dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_sr_clk    (i_sr_clk),
    .i_sr_latch  (i_sr_latch),
    .i_sr_bit    (i_sr_bit),
    .o_seconds   (o_seconds),
    .o_minutes   (o_minutes),
    .o_hours     (o_hours),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) if (o_valid === 1'b1) vcount++;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] bcd(int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [23:0] exp_time();
    return {bcd(exp_h), bcd(exp_m), bcd(exp_s)};
  endfunction

  function automatic int seg_to_dig(logic [7:0] b);
    for (int i = 0; i < 10; i++) if (segs[i] == b) return i;
    return -1;
  endfunction

  // Frame bytes for a time; seconds units first, MSB of each byte first.
  function automatic logic [47:0] make_frame(int h, int m, int s);
    int d[6];
    logic [47:0] f;
    d = '{s % 10, s / 10, m % 10, m / 10, h % 10, h / 10};
    for (int k = 0; k < 6; k++) f[47-8*k -: 8] = segs[d[k]];
    return f;
  endfunction

  function automatic void model_latch();
    int d[6];
    int s, m, h;
    logic [7:0] b;
    bit ok;
    ok = (bitq.size() == 48);
    for (int k = 0; k < 6 && ok; k++) begin
      b = 8'h00;
      for (int j = 0; j < 8; j++) b = {b[6:0], bitq[8*k+j]};
      d[k] = seg_to_dig(b);
      if (d[k] < 0) ok = 1'b0;
    end
    if (ok) begin
      s = d[1] * 10 + d[0];
      m = d[3] * 10 + d[2];
      h = d[5] * 10 + d[4];
      ok = (s < 60) && (m < 60) && (h < 24);
    end
    if (ok) begin
      exp_s = s; exp_m = m; exp_h = h;
      exp_err = 1'b0; exp_pulses = 1;
    end else begin
      exp_err = 1'b1; exp_pulses = 0;
    end
    bitq.delete();
  endfunction

  function automatic void model_reset();
    bitq.delete();
    exp_s = 0; exp_m = 0; exp_h = 0;
    exp_err = 1'b0; exp_pulses = 0;
  endfunction

  task automatic wait_cyc(int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic send_bit(bit b);
    i_sr_bit = b;
    wait_cyc(4);
    i_sr_clk = 1'b1;
    wait_cyc(4);
    i_sr_clk = 1'b0;
    wait_cyc(4);
    bitq.push_back(b);
  endtask

  task automatic send_frame(logic [47:0] f, int n);
    for (int i = 0; i < n; i++) send_bit(i < 48 ? f[47-i] : 1'($urandom % 2));
  endtask

  task automatic do_latch();
    vcount = 0;
    i_sr_latch = 1'b1;
    wait_cyc(4);
    i_sr_latch = 1'b0;
    wait_cyc(6);
    model_latch();
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    wait_cyc(3);
    vectors++;
    if ({o_hours, o_minutes, o_seconds, o_valid, o_frame_err} !== 26'h0) begin
      miscompares++;
      $display("FAIL reset_hold: got %h:%h:%h v=%b e=%b want 00:00:00 v=0 e=0",
               o_hours, o_minutes, o_seconds, o_valid, o_frame_err);
    end
    i_rst = 1'b0;
    model_reset();
    vcount = 0;
    wait_cyc(10);
    vectors++;
    if ({o_hours, o_minutes, o_seconds, o_frame_err} !== 25'h0 || vcount != 0) begin
      miscompares++;
      $display("FAIL reset_idle: got %h:%h:%h e=%b pulses=%0d want all zero",
               o_hours, o_minutes, o_seconds, o_frame_err, vcount);
    end
  endtask

  task automatic test_frame(string name, logic [47:0] f, int n);
    send_frame(f, n);
    do_latch();
    vectors++;
    if ({o_hours, o_minutes, o_seconds} !== exp_time()) begin
      miscompares++;
      $display("FAIL %s time: got %h want %h", name,
               {o_hours, o_minutes, o_seconds}, exp_time());
    end
    vectors++;
    if (o_frame_err !== exp_err) begin
      miscompares++;
      $display("FAIL %s err: got %b want %b", name, o_frame_err, exp_err);
    end
    vectors++;
    if (vcount != exp_pulses) begin
      miscompares++;
      $display("FAIL %s valid_cycles: got %0d want %0d", name, vcount, exp_pulses);
    end
  endtask

  task automatic test_good_frame();
    logic [47:0] f;
    f = make_frame(12, 34, 56);
    vectors++;
    if (f !== 48'h7D6D664F5B06) begin
      miscompares++;
      $display("FAIL frame_bytes: got %h want 7d6d664f5b06", f);
    end
    test_frame("good_123456", f, 48);
    vectors++;
    if ({o_hours, o_minutes, o_seconds} !== 24'h123456) begin
      miscompares++;
      $display("FAIL good_literal: got %h want 123456", {o_hours, o_minutes, o_seconds});
    end
  endtask

  task automatic test_short_long();
    test_frame("short_47", make_frame(1, 2, 3), 47);
    test_frame("good_235959", make_frame(23, 59, 59), 48);
    test_frame("empty_latch", make_frame(0, 0, 0), 0);
    test_frame("good_after_empty", make_frame(4, 5, 6), 48);
  endtask

  task automatic test_bad_frames();
    logic [47:0] f;
    f = make_frame(1, 2, 3);
    f[47:40] = 8'h00;
    test_frame("blank_byte", f, 48);
    test_frame("min_tens_6", make_frame(10, 65, 10), 48);
    test_frame("hour_24", make_frame(24, 0, 0), 48);
    f = make_frame(8, 8, 8);
    f[23] = 1'b1;
    test_frame("dp_set", f, 48);
  endtask

  task automatic test_reset_midframe();
    send_frame(make_frame(9, 9, 9), 20);
    i_rst = 1'b1;
    wait_cyc(3);
    i_rst = 1'b0;
    model_reset();
    wait_cyc(4);
    vectors++;
    if ({o_hours, o_minutes, o_seconds, o_frame_err} !== 25'h0) begin
      miscompares++;
      $display("FAIL midreset_clear: got %h:%h:%h e=%b want zero",
               o_hours, o_minutes, o_seconds, o_frame_err);
    end
    test_frame("after_reset_000001", make_frame(0, 0, 1), 48);
    test_frame("short_after_reset", make_frame(0, 0, 2), 30);
  endtask

  task automatic test_simultaneous();
    logic [47:0] f;
    f = make_frame(17, 42, 8);
    send_frame(f, 47);
    i_sr_bit = f[0];
    wait_cyc(4);
    vcount = 0;
    i_sr_clk = 1'b1;
    i_sr_latch = 1'b1;
    bitq.push_back(f[0]);
    wait_cyc(4);
    i_sr_clk = 1'b0;
    i_sr_latch = 1'b0;
    wait_cyc(6);
    model_latch();
    vectors++;
    if ({o_hours, o_minutes, o_seconds} !== exp_time() || o_frame_err !== exp_err ||
        vcount != exp_pulses) begin
      miscompares++;
      $display("FAIL simultaneous: got %h e=%b pulses=%0d want %h e=%b pulses=%0d",
               {o_hours, o_minutes, o_seconds}, o_frame_err, vcount,
               exp_time(), exp_err, exp_pulses);
    end
    test_frame("long_49", make_frame(1, 1, 1), 49);
  endtask

  task automatic test_latency();
    send_frame(make_frame(7, 8, 9), 48);
    model_latch();
    i_sr_latch = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      @(posedge i_clk);
      #1;
      vectors++;
      if (o_valid !== (e == 3)) begin
        miscompares++;
        $display("FAIL latency_edge%0d: valid got %b want %b", e, o_valid, e == 3);
      end
    end
    vectors++;
    if ({o_hours, o_minutes, o_seconds} !== exp_time()) begin
      miscompares++;
      $display("FAIL latency_time: got %h want %h", {o_hours, o_minutes, o_seconds}, exp_time());
    end
    i_sr_latch = 1'b0;
    wait_cyc(6);
  endtask

  task automatic test_random();
    logic [47:0] f;
    int kind, n;
    for (int it = 0; it < 14; it++) begin
      kind = int'($urandom_range(0, 5));
      n = 48;
      f = make_frame(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)),
                     int'($urandom_range(0, 59)));
      case (kind)
        1: f[47 - 8 * int'($urandom_range(0, 5)) -: 8] = 8'($urandom);
        2: f = make_frame(int'($urandom_range(0, 99)), int'($urandom_range(0, 99)),
                          int'($urandom_range(0, 99)));
        3: begin
          n = int'($urandom_range(1, 55));
          if (n == 48) n = 50;
        end
        default: ;
      endcase
      test_frame($sformatf("random_%0d", it), f, n);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_short_long();
    test_bad_frames();
    test_reset_midframe();
    test_simultaneous();
    test_latency();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
